// File: rtl/spart_rx_fifo.sv
// -----------------------------------------------------------------------------
// spart_rx_fifo
//
// Receive path of the SPART: oversampled UART deserialiser with mid-bit
// sampling, optional parity, framing/parity/overrun detection and a
// show-ahead receive FIFO. Baud generation is external; `enable` is the
// oversample tick (OVERSAMPLE ticks per bit period).
//
// Ports:
//   clk         system clock
//   rst         asynchronous, active-high reset
//   enable      oversample tick, one clk wide
//   rxd         serial line, idle high, asynchronous to clk
//   rd_en       pop the FIFO head (ignored when empty)
//   err_clr     clear all sticky error flags
//   rx_data     FIFO head (show-ahead), 0 when empty
//   rda         FIFO not empty
//   fifo_count  number of entries held
//   frame_err   sticky: stop bit sampled low
//   parity_err  sticky: parity mismatch
//   overrun     sticky: good frame arrived while the FIFO was full
//
// Receiver states:
//   state    | meaning
//   ---------+----------------------------------------------------------
//   S_IDLE   | line idle, waiting for a falling edge on rxs
//   S_START  | half a bit period into the start bit, checking it is real
//   S_DATA   | sampling DATA_BITS data bits at mid-bit, LSB first
//   S_PARITY | sampling the parity bit (only when PARITY_EN)
//   S_STOP   | sampling the stop bit, deciding push / error
//   S_BRK    | stop bit was low; wait for the line to return high
// -----------------------------------------------------------------------------
module spart_rx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 enable,
    input  logic                                 rxd,
    input  logic                                 rd_en,
    input  logic                                 err_clr,
    output logic [DATA_BITS-1:0]                 rx_data,
    output logic                                 rda,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_count,
    output logic                                 frame_err,
    output logic                                 parity_err,
    output logic                                 overrun
);

    localparam int TW    = $clog2(OVERSAMPLE);
    localparam int BW    = $clog2(DATA_BITS);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CW    = $clog2(FIFO_DEPTH + 1);

    localparam logic [TW-1:0] T_HALF  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_LAST  = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST  = BW'(DATA_BITS - 1);
    localparam logic [CW-1:0] C_FULL  = CW'(FIFO_DEPTH);
    localparam logic          ODD_BIT = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BRK
    } state_t;

    // ------------------------------------------------------------------
    // rxd synchroniser; both flops reset to the idle (high) level so a
    // reset never looks like a start bit.
    // ------------------------------------------------------------------
    logic sync1_q;
    logic rxs_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            rxs_q   <= 1'b1;
        end else begin
            sync1_q <= rxd;
            rxs_q   <= sync1_q;
        end
    end

    // ------------------------------------------------------------------
    // Receiver FSM
    // ------------------------------------------------------------------
    state_t                 state_q, state_d;
    logic [TW-1:0]          tcnt_q, tcnt_d;
    logic [BW-1:0]          bcnt_q, bcnt_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic                   perr_q, perr_d;

    // One-cycle outcome strobes from the stop-bit sample
    logic frame_ok;
    logic frame_bad;
    logic frame_perr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            tcnt_q  <= '0;
            bcnt_q  <= '0;
            shreg_q <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            bcnt_q  <= bcnt_d;
            shreg_q <= shreg_d;
            perr_q  <= perr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tcnt_d     = tcnt_q;
        bcnt_d     = bcnt_q;
        shreg_d    = shreg_q;
        perr_d     = perr_q;
        frame_ok   = 1'b0;
        frame_bad  = 1'b0;
        frame_perr = 1'b0;

        if (enable) begin
            case (state_q)
                S_IDLE: begin
                    if (!rxs_q) begin
                        state_d = S_START;
                        tcnt_d  = '0;
                    end
                end

                S_START: begin
                    if (tcnt_q == T_HALF) begin
                        if (rxs_q) begin
                            // Line went back high before mid start bit: glitch.
                            state_d = S_IDLE;
                        end else begin
                            // From here on tcnt wraps at a full bit period,
                            // so every later sample lands mid-bit.
                            state_d = S_DATA;
                            tcnt_d  = '0;
                            bcnt_d  = '0;
                            perr_d  = 1'b0;
                        end
                    end else begin
                        tcnt_d = tcnt_q + TW'(1);
                    end
                end

                S_DATA: begin
                    if (tcnt_q == T_LAST) begin
                        tcnt_d  = '0;
                        // Shift in at the MSB so the first (LSB) bit ends at bit 0.
                        shreg_d = {rxs_q, shreg_q[DATA_BITS-1:1]};
                        if (bcnt_q == B_LAST) begin
                            state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                        end else begin
                            bcnt_d = bcnt_q + BW'(1);
                        end
                    end else begin
                        tcnt_d = tcnt_q + TW'(1);
                    end
                end

                S_PARITY: begin
                    if (tcnt_q == T_LAST) begin
                        tcnt_d  = '0;
                        // Expected bit makes the total ones count even (or odd).
                        perr_d  = rxs_q != ((^shreg_q) ^ ODD_BIT);
                        state_d = S_STOP;
                    end else begin
                        tcnt_d = tcnt_q + TW'(1);
                    end
                end

                S_STOP: begin
                    if (tcnt_q == T_LAST) begin
                        tcnt_d = '0;
                        if (!rxs_q) begin
                            frame_bad = 1'b1;
                            state_d   = S_BRK;
                        end else if (perr_q) begin
                            frame_perr = 1'b1;
                            state_d    = S_IDLE;
                        end else begin
                            frame_ok = 1'b1;
                            state_d  = S_IDLE;
                        end
                    end else begin
                        tcnt_d = tcnt_q + TW'(1);
                    end
                end

                S_BRK: begin
                    // A held-low line must not be re-read as further frames.
                    if (rxs_q) begin
                        state_d = S_IDLE;
                    end
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Receive FIFO (show-ahead)
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;

    logic fifo_empty;
    logic fifo_full;
    logic push;
    logic pop;
    logic ovr_set;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == C_FULL);
    assign pop        = rd_en && !fifo_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push       = frame_ok && (!fifo_full || pop);
    assign ovr_set    = frame_ok && fifo_full && !pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is masked to 0 while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= shreg_q;
        end
    end

    // ------------------------------------------------------------------
    // Sticky error flags: a set in the same cycle as err_clr wins.
    // ------------------------------------------------------------------
    logic frame_err_q, frame_err_d;
    logic parity_err_q, parity_err_d;
    logic overrun_q, overrun_d;

    always_comb begin
        frame_err_d  = frame_err_q  && !err_clr;
        parity_err_d = parity_err_q && !err_clr;
        overrun_d    = overrun_q    && !err_clr;
        if (frame_bad) begin
            frame_err_d = 1'b1;
        end
        if (frame_perr) begin
            parity_err_d = 1'b1;
        end
        if (ovr_set) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rx_data    = fifo_empty ? '0 : mem_q[rd_ptr_q];
    assign rda        = !fifo_empty;
    assign fifo_count = count_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;

endmodule
